// File: rtl/serial_adder_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the bit-serial adder.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder cell.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic sum,
    output logic carry
);

    assign sum   = A ^ B ^ C;
    assign carry = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder cell stepped LSB first over WIDTH bits.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc_sr;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_sum;
    logic             fa_carry;
    logic             last;

    full_adder u_fa (
        .A     (a_sr[0]),
        .B     (b_sr[0]),
        .C     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign last    = (state == S_RUN) && (cnt == LAST);
    assign acc_nxt = WIDTH'({fa_sum, acc_sr} >> 1);
    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Reserved code falls through to IDLE.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = start ? S_RUN : S_IDLE;
            S_RUN:   state_nxt = last ? S_DONE : S_RUN;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            acc_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (state == S_IDLE && start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            acc_sr <= acc_nxt;
            carry  <= fa_carry;
            cnt    <= cnt + CW'(1);
            if (last) begin
                sum  <= acc_nxt;
                cout <= fa_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

    typedef struct {
        logic [8:0] res;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   bcnt8 = 0;
    int   bcnt1 = 0;
    exp_t q8[$];
    exp_t q1[$];
    exp_t e8;
    exp_t e1;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (rst) begin
            bcnt8 = 0;
        end else begin
            if (busy8) bcnt8++;
            if (done8) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d8_extra_done: done at cycle %0d, none expected",
                             cyc);
                end else begin
                    e8 = q8.pop_front();
                    chk("d8_sum", 32'(sum8), 32'(e8.res[7:0]));
                    chk("d8_cout", 32'(cout8), 32'(e8.res[8]));
                    chk("d8_latency", 32'(cyc), 32'(e8.t));
                    chk("d8_busy_cycles", 32'(bcnt8), 32'd8);
                end
                bcnt8 = 0;
            end
        end
    end

    // Monitor for the 1-bit instance
    always @(negedge clk) begin
        if (rst) begin
            bcnt1 = 0;
        end else begin
            if (busy1) bcnt1++;
            if (done1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d1_extra_done: done at cycle %0d, none expected",
                             cyc);
                end else begin
                    e1 = q1.pop_front();
                    chk("d1_cout_sum", 32'({cout1, sum1}), 32'(e1.res[1:0]));
                    chk("d1_latency", 32'(cyc), 32'(e1.t));
                    chk("d1_busy_cycles", 32'(bcnt1), 32'd1);
                end
                bcnt1 = 0;
            end
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [8:0] exp);
        @(negedge clk);
        a8     = a;
        b8     = b;
        cin8   = c;
        start8 = 1'b1;
        q8.push_back('{res: exp, t: cyc + 1 + 8});
        @(negedge clk);
        start8 = 1'b0;
        a8     = ~a;
        b8     = ~b;
        cin8   = ~c;
        repeat (8) @(negedge clk);
    endtask

    task automatic run1(input logic [2:0] abc, input logic [1:0] exp);
        @(negedge clk);
        a1     = abc[2];
        b1     = abc[1];
        cin1   = abc[0];
        start1 = 1'b1;
        q1.push_back('{res: 9'(exp), t: cyc + 1 + 1});
        @(negedge clk);
        start1 = 1'b0;
        a1     = ~abc[2];
        b1     = ~abc[1];
        cin1   = ~abc[0];
        repeat (2) @(negedge clk);
    endtask

    logic [1:0]  fa_tab [8];
    logic [16:0] b2b_ops [4];
    int          acc;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        fa_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        b2b_ops = '{{8'h12, 8'h34, 1'b0}, {8'hC3, 8'h3C, 1'b1},
                    {8'h80, 8'h80, 1'b0}, {8'h7F, 8'h00, 1'b1}};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        rst = 1'b0;

        // Basic adds and carry boundaries
        run8(8'h5A, 8'h33, 1'b0, 9'h08D);
        run8(8'hFF, 8'h01, 1'b0, 9'h100);
        run8(8'hFF, 8'hFF, 1'b1, 9'h1FF);

        // Start re-pulsed mid-RUN must be ignored
        @(negedge clk);
        a8     = 8'h5A;
        b8     = 8'h33;
        cin8   = 1'b0;
        start8 = 1'b1;
        q8.push_back('{res: 9'h08D, t: cyc + 1 + 8});
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        a8     = 8'h00;
        b8     = 8'h00;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (6) @(negedge clk);

        // Reset during the 4th RUN cycle abandons the operation
        @(negedge clk);
        a8     = 8'h11;
        b8     = 8'h22;
        cin8   = 1'b1;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy8), 32'd0);
        chk("midrst_done", 32'(done8), 32'd0);
        chk("midrst_sum", 32'(sum8), 32'd0);
        chk("midrst_cout", 32'(cout8), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_idle_busy", 32'(busy8), 32'd0);
        run8(8'h0F, 8'hF0, 1'b1, 9'h100);

        // WIDTH=1 truth table
        for (int i = 0; i < 8; i++) run1(3'(i), fa_tab[i]);

        // Start held high: back-to-back every WIDTH+2 edges
        @(negedge clk);
        acc    = cyc + 1;
        start8 = 1'b1;
        {a8, b8, cin8} = b2b_ops[0];
        for (int i = 0; i < 4; i++) begin
            q8.push_back('{res: {1'b0, b2b_ops[i][16:9]} +
                                {1'b0, b2b_ops[i][8:1]} +
                                9'(b2b_ops[i][0]),
                           t: acc + 8});
            while (cyc < acc) @(negedge clk);
            if (i < 3) {a8, b8, cin8} = b2b_ops[i + 1];
            else start8 = 1'b0;
            acc += 10;
        end

        // Drain outstanding expectations
        for (int n = 0; n < 40 && (q8.size() != 0 || q1.size() != 0); n++)
            @(negedge clk);
        if (q8.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d results never appeared",
                     q8.size(), q1.size());
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
